// File: rtl/noc_packet_sender.sv
// noc_packet_sender: latches a whole packet, then injects HEADER, DATA..., TAIL flits with stall and bounded header retry
module noc_packet_sender #(
    parameter int MAX_PACKET_BITS = 64,
    parameter int PADDING_BITS = 0,
    parameter int MAX_RETRIES = 3,
    parameter int BACKOFF_CYCLES = 4,
    parameter int FLIT_DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    localparam int FW = FLIT_DATA_WIDTH,
    localparam int MAX_FLITS = (MAX_PACKET_BITS + FW - 1) / FW,
    localparam int LW = $clog2(MAX_FLITS + 1),
    localparam int PW = PADDING_BITS > 0 ? PADDING_BITS : 1,
    localparam int FLIT_W = FW + 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [ADDR_WIDTH-1:0]      in_dst_i,
    input  logic [PW-1:0]              in_padding_i,
    input  logic [MAX_PACKET_BITS-1:0] in_packet_i,
    input  logic [LW-1:0]              in_len_i,
    output logic                       done_o,
    output logic                       err_o,
    output logic                       busy_o,
    output logic                       up_enable_o,
    output logic [FLIT_W-1:0]          up_flit_o,
    input  logic                       up_ack_i,
    input  logic                       up_rej_i
);
    localparam int CW = MAX_FLITS > 1 ? $clog2(MAX_FLITS) : 1;
    localparam int RW = MAX_RETRIES > 0 ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int BW = $clog2(BACKOFF_CYCLES + 1);
    localparam logic [1:0] T_HDR = 2'd1, T_DATA = 2'd2, T_TAIL = 2'd3;
    localparam logic [PW-1:0] PAD_MASK = PADDING_BITS > 0 ? '1 : '0;
    typedef enum logic [1:0] {IDLE, HEADER, BACKOFF, SENDING} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [BW-1:0] bo_q, bo_d;
    logic done_d, err_d;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [PW-1:0] pad_q;
    logic [MAX_FLITS-1:0][FW-1:0] pkt_q;
    logic [LW-1:0] len_q;
    logic accept, is_tail;
    logic [FW-1:0] hdr;
    assign accept = in_valid_i && state_q == IDLE;
    assign is_tail = LW'(cnt_q) + LW'(1) == len_q;
    // Header data: dst in the low bits, padding directly above it.
    assign hdr = FW'(dst_q) | (FW'(pad_q) << ADDR_WIDTH);
    assign in_ready_o = state_q == IDLE;
    assign busy_o = state_q != IDLE;
    assign up_enable_o = state_q == HEADER || state_q == SENDING;
    assign up_flit_o = state_q == HEADER  ? {T_HDR, hdr} :
                       state_q == SENDING ? {is_tail ? T_TAIL : T_DATA, pkt_q[cnt_q]} : '0;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        retry_d = retry_q;
        bo_d = bo_q;
        done_d = 1'b0;
        err_d = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                state_d = HEADER;
                retry_d = '0;
            end
            HEADER: if (up_ack_i) begin
                state_d = SENDING;
                cnt_d = '0;
            end else if (up_rej_i && retry_q < RW'(MAX_RETRIES)) begin
                state_d = BACKOFF;
                retry_d = retry_q + RW'(1);
                bo_d = BW'(BACKOFF_CYCLES);
            end else if (up_rej_i) begin
                state_d = IDLE;
                err_d = 1'b1;
            end
            BACKOFF: begin
                bo_d = bo_q - BW'(1);
                state_d = bo_q == BW'(1) ? HEADER : BACKOFF;
            end
            SENDING: if (up_ack_i) begin
                cnt_d = cnt_q + CW'(1);
                state_d = is_tail ? IDLE : SENDING;
                done_d = is_tail;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            retry_q <= '0;
            bo_q <= '0;
            done_o <= 1'b0;
            err_o <= 1'b0;
            dst_q <= '0;
            pad_q <= '0;
            pkt_q <= '0;
            len_q <= LW'(1);
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            retry_q <= retry_d;
            bo_q <= bo_d;
            done_o <= done_d;
            err_o <= err_d;
            if (accept) begin
                dst_q <= in_dst_i;
                pad_q <= in_padding_i & PAD_MASK;
                pkt_q <= (MAX_FLITS * FW)'(in_packet_i);
                len_q <= in_len_i == '0 ? LW'(1) : in_len_i > LW'(MAX_FLITS) ? LW'(MAX_FLITS) : in_len_i;
            end
        end
    end
endmodule

// File: tb/tb_noc_packet_sender.sv
// tb_noc_packet_sender: directed checks of flit sequencing, stall, retry/backoff, error and reset abort
module tb_noc_packet_sender;
    logic clk = 0, rst = 1, in_valid = 0, in_ready, done, err, busy, en, ack = 0, rej = 0;
    logic [7:0] dst = 0;
    logic [3:0] pad = 0;
    logic [63:0] pkt = 0;
    logic [2:0] len = 0;
    logic [17:0] flit;
    int checks = 0, failures = 0;
    noc_packet_sender #(.MAX_PACKET_BITS(64), .PADDING_BITS(4), .MAX_RETRIES(2), .BACKOFF_CYCLES(3),
                        .FLIT_DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .in_dst_i(dst),
        .in_padding_i(pad), .in_packet_i(pkt), .in_len_i(len), .done_o(done), .err_o(err),
        .busy_o(busy), .up_enable_o(en), .up_flit_o(flit), .up_ack_i(ack), .up_rej_i(rej));
    always #5 clk = ~clk;
    localparam logic [17:0] HDR = {2'd1, 16'h0CA5};
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic send(input logic [63:0] p, input logic [2:0] l);
        pkt = p; len = l; dst = 8'hA5; pad = 4'hC; in_valid = 1;
        step();
        in_valid = 0; pkt = '1; dst = 0; pad = 0; len = 0;
        chk("hdr_en", 32'(en), 1);
        chk("hdr_flit", 32'(flit), 32'(HDR));
    endtask
    task automatic flit_chk(input string tag, input logic [1:0] t, input logic [15:0] d);
        chk(tag, 32'({en, flit}), 32'({1'b1, t, d}));
    endtask
    initial begin
        step(); step();
        rst = 0;
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_out", 32'({en, flit, busy, done, err}), 0);
        // 1: full-length packet with continuous ack
        ack = 1;
        send(64'hDDDD_CCCC_BBBB_AAAA, 3'd4);
        step(); flit_chk("t1_d0", 2'd2, 16'hAAAA);
        chk("t1_busy", 32'({busy, in_ready}), 32'b10);
        step(); flit_chk("t1_d1", 2'd2, 16'hBBBB);
        step(); flit_chk("t1_d2", 2'd2, 16'hCCCC);
        step(); flit_chk("t1_tail", 2'd3, 16'hDDDD);
        chk("t1_nodone", 32'(done), 0);
        step(); chk("t1_done", 32'({done, err, en, in_ready}), 32'b1001);
        // 2: len=2 with ack dropped during the tail flit
        send(64'h0000_0000_BBBB_AAAA, 3'd2);
        chk("t2_done_clr", 32'(done), 0);
        step(); flit_chk("t2_d0", 2'd2, 16'hAAAA);
        step(); flit_chk("t2_tail", 2'd3, 16'hBBBB);
        ack = 0;
        step(); flit_chk("t2_stall1", 2'd3, 16'hBBBB);
        step(); flit_chk("t2_stall2", 2'd3, 16'hBBBB);
        chk("t2_nodone", 32'(done), 0);
        ack = 1;
        step(); chk("t2_done", 32'({done, en}), 32'b10);
        step(); chk("t2_idle", 32'({done, en, in_ready}), 32'b001);
        // 3: two header rejects then ack; each retry after exactly 3 idle cycles
        ack = 0;
        send(64'h1234, 3'd1);
        for (int r = 0; r < 2; r++) begin
            rej = 1;
            step(); rej = 0;
            chk("t3_bo1", 32'({en, flit, busy}), 1);
            step(); chk("t3_bo2", 32'({en, flit}), 0);
            step(); chk("t3_bo3", 32'({en, flit}), 0);
            step(); chk("t3_rehdr", 32'({en, flit}), 32'({1'b1, HDR}));
        end
        ack = 1;
        step(); flit_chk("t3_tail", 2'd3, 16'h1234);
        step(); chk("t3_done", 32'({done, err}), 32'b10);
        // 4: three rejects exhaust retries
        ack = 0;
        send(64'h5555, 3'd1);
        for (int r = 0; r < 2; r++) begin
            rej = 1;
            step(); rej = 0;
            step(); step();
            step(); chk("t4_rehdr", 32'({en, flit}), 32'({1'b1, HDR}));
        end
        rej = 1;
        step(); rej = 0;
        chk("t4_err", 32'({err, done, en, in_ready, busy}), 32'b10010);
        step(); chk("t4_err_clr", 32'({err, en}), 0);
        // 5: len=0 as one tail (ack+rej together: ack wins), len=7 clamped to 4
        ack = 1; rej = 1;
        send(64'hDDDD_CCCC_BBBB_AAAA, 3'd0);
        step(); rej = 0;
        flit_chk("t5_len0_tail", 2'd3, 16'hAAAA);
        step(); chk("t5_len0_done", 32'({done, err}), 32'b10);
        send(64'hDDDD_CCCC_BBBB_AAAA, 3'd7);
        step(); flit_chk("t5_d0", 2'd2, 16'hAAAA);
        step(); step(); flit_chk("t5_d2", 2'd2, 16'hCCCC);
        step(); flit_chk("t5_tail", 2'd3, 16'hDDDD);
        step(); chk("t5_done", 32'(done), 1);
        // 6: reset mid-packet, then a clean packet
        send(64'hDDDD_CCCC_BBBB_AAAA, 3'd4);
        step(); step(); step(); flit_chk("t6_cnt2", 2'd2, 16'hCCCC);
        rst = 1;
        step(); rst = 0;
        chk("t6_abort", 32'({en, flit, in_ready, done, err}), 32'b100);
        step(); chk("t6_quiet", 32'({en, done}), 0);
        send(64'h0000_0000_0000_7777, 3'd1);
        step(); flit_chk("t6_tail", 2'd3, 16'h7777);
        step(); chk("t6_done", 32'({done, in_ready}), 32'b11);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
